mem_access_ctrl: RTL and testbench

- MEM-stage controller that turns load/store micro-ops into transactions on the SRAM-like data bus (req / addr_ok / data_ok).
- Detects misaligned accesses (AdEL/AdES), forms size and replicated store data, and stalls the pipeline until the bus completes.
- Returns the raw read word. The downstream load-extension logic selects the byte/halfword lane using addr[1:0] and the same op code.

---
 rtl/mem_access_ctrl_pkg.sv | 18 +
 rtl/mem_align_chk.sv | 60 ++++++
 rtl/mem_access_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage access controller: ALU op codes for
// loads/stores and the bus transfer-size encoding.
package mem_access_ctrl_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_align_chk.sv
// Op decode for the MEM stage: load/store class, alignment faults, bus size
// and lane-replicated store data. Purely combinational, ungated by valid.
module mem_align_chk
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [7:0]        op_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              is_load_o,
    output logic              is_store_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic [1:0]        size_o,
    output logic [DATA_W-1:0] wdata_o
);

    always_comb begin
        is_load_o  = 1'b0;
        is_store_o = 1'b0;
        adel_o     = 1'b0;
        ades_o     = 1'b0;
        size_o     = SIZE_BYTE;
        wdata_o    = '0;
        case (op_i)
            EXE_LB_OP, EXE_LBU_OP: begin
                is_load_o = 1'b1;
            end
            EXE_LH_OP, EXE_LHU_OP: begin
                is_load_o = 1'b1;
                size_o    = SIZE_HALF;
                adel_o    = addr_lo_i[0];
            end
            EXE_LW_OP: begin
                is_load_o = 1'b1;
                size_o    = SIZE_WORD;
                adel_o    = |addr_lo_i;
            end
            EXE_SB_OP: begin
                is_store_o = 1'b1;
                wdata_o    = {4{wdata_i[7:0]}};
            end
            EXE_SH_OP: begin
                is_store_o = 1'b1;
                size_o     = SIZE_HALF;
                ades_o     = addr_lo_i[0];
                wdata_o    = {2{wdata_i[15:0]}};
            end
            EXE_SW_OP: begin
                is_store_o = 1'b1;
                size_o     = SIZE_WORD;
                ades_o     = |addr_lo_i;
                wdata_o    = wdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller driving an SRAM-like req/addr_ok/data_ok
// bus; stalls the pipeline until the transfer completes.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic [7:0]        mem_op,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              flush,
    output logic              stall_o,
    output logic              adel,
    output logic              ades,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              wr_q, wr_d;
    logic              load_q, load_d;
    logic              drop_q, drop_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvld_q, rvld_d;

    logic              chk_load, chk_store, chk_adel, chk_ades;
    logic [1:0]        chk_size;
    logic [DATA_W-1:0] chk_wdata;
    logic              op_live, start;

    mem_align_chk #(.DATA_W(DATA_W)) u_chk (
        .op_i       (mem_op),
        .addr_lo_i  (mem_addr[1:0]),
        .wdata_i    (mem_wdata),
        .is_load_o  (chk_load),
        .is_store_o (chk_store),
        .adel_o     (chk_adel),
        .ades_o     (chk_ades),
        .size_o     (chk_size),
        .wdata_o    (chk_wdata)
    );

    assign op_live = resetn & mem_valid & ~flush;
    assign adel    = op_live & chk_adel;
    assign ades    = op_live & chk_ades;
    assign start   = op_live & (chk_load | chk_store) & ~chk_adel & ~chk_ades
                   & (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        wr_d    = wr_q;
        load_d  = load_q;
        drop_d  = drop_q;
        rdata_d = rdata_q;
        rvld_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = mem_addr;
                    wdata_d = chk_wdata;
                    size_d  = chk_size;
                    wr_d    = chk_store;
                    load_d  = chk_load;
                    drop_d  = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Once the address is accepted the transfer must drain even if flushed.
                if (data_addr_ok) begin
                    state_d = S_WAIT;
                    drop_d  = drop_q | flush;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                drop_d = drop_q | flush;
                if (data_data_ok) begin
                    if (load_q && !drop_q && !flush) begin
                        rdata_d = data_rdata;
                        rvld_d  = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SIZE_BYTE;
            wr_q    <= 1'b0;
            load_q  <= 1'b0;
            drop_q  <= 1'b0;
            rdata_q <= '0;
            rvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            wr_q    <= wr_d;
            load_q  <= load_d;
            drop_q  <= drop_d;
            rdata_q <= rdata_d;
            rvld_q  <= rvld_d;
        end
    end

    // Bus fields are only meaningful while requesting; zero them otherwise.
    assign data_req    = (state_q == S_REQ);
    assign data_wr     = data_req & wr_q;
    assign data_size   = data_req ? size_q  : SIZE_BYTE;
    assign data_addr   = data_req ? addr_q  : '0;
    assign data_wdata  = data_req ? wdata_q : '0;

    assign stall_o     = start | (state_q == S_REQ) | (state_q == S_WAIT);
    assign rdata_o     = rdata_q;
    assign rdata_valid = rvld_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a load-data scoreboard.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn, mem_valid, flush, data_addr_ok, data_data_ok;
    logic [7:0]  mem_op;
    logic [31:0] mem_addr, mem_wdata, data_rdata;
    logic        stall_o, adel, ades, rdata_valid, data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] rdata_o, data_addr, data_wdata;

    int checks = 0;
    int passes = 0;
    logic [31:0] sbq[$];
    logic [31:0] last_rd = '0;

    mem_access_ctrl dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_op(mem_op),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .flush(flush),
        .stall_o(stall_o), .adel(adel), .ades(ades), .rdata_o(rdata_o),
        .rdata_valid(rdata_valid), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rdata_valid pulse must match the oldest expected load.
    always @(negedge clk) begin
        if (rdata_valid === 1'b1) begin
            if (sbq.size() == 0) chk("sb_unexpected_rvld", 32'd1, 32'd0);
            else chk("sb_rdata", rdata_o, sbq.pop_front());
        end
    end

    // Zero-wait transfer: IDLE(start) -> REQ(addr_ok) -> WAIT(data_ok) -> DONE -> IDLE.
    task automatic xact(input string nm, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input logic ewr,
                        input logic [1:0] esz, input logic [31:0] ewd);
        mem_valid = 1'b1; mem_op = op; mem_addr = addr; mem_wdata = wd;
        mid();
        chk({nm, "_start_stall"}, stall_o, 1'b1);
        chk({nm, "_start_noreq"}, data_req, 1'b0);
        chk({nm, "_noerr"}, {adel, ades}, 2'b00);
        if (!ewr) begin sbq.push_back(rd); last_rd = rd; end
        adv();
        data_addr_ok = 1'b1;
        mid();
        chk({nm, "_req"}, data_req, 1'b1);
        chk({nm, "_wr"}, data_wr, ewr);
        chk({nm, "_size"}, data_size, esz);
        chk({nm, "_addr"}, data_addr, addr);
        chk({nm, "_wdata"}, data_wdata, ewd);
        adv();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rd;
        mid();
        chk({nm, "_wait"}, {stall_o, data_req}, 2'b10);
        adv();
        data_data_ok = 1'b0; data_rdata = 32'hFFFF_FFFF;
        mid();
        chk({nm, "_done"}, {stall_o, data_req}, 2'b00);
        adv();
        mem_valid = 1'b0;
        mid();
        chk({nm, "_idle_noreq"}, data_req, 1'b0);
        chk({nm, "_rdata_hold"}, rdata_o, last_rd);
        adv();
    endtask

    initial begin
        resetn = 1'b0; mem_valid = 1'b0; flush = 1'b0; mem_op = 8'h00;
        mem_addr = '0; mem_wdata = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        data_rdata = '0;
        adv(); adv();
        mid();
        chk("rst_outs", {stall_o, adel, ades, rdata_valid, data_req, data_wr}, 6'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        resetn = 1'b1;
        adv();

        // LW with addr_ok delayed one cycle and data_ok one cycle after WAIT entry.
        mem_valid = 1'b1; mem_op = EXE_LW_OP; mem_addr = 32'h1000_0004;
        mid(); chk("lw_c0", {stall_o, data_req}, 2'b10);
        sbq.push_back(32'hDEAD_BEEF); last_rd = 32'hDEAD_BEEF;
        adv();
        mid(); chk("lw_c1", {stall_o, data_req, data_wr}, 3'b110);
        chk("lw_c1_addr", data_addr, 32'h1000_0004);
        chk("lw_c1_size", data_size, SIZE_WORD);
        adv();
        data_addr_ok = 1'b1;
        mid(); chk("lw_c2", {stall_o, data_req}, 2'b11);
        adv();
        data_addr_ok = 1'b0;
        mid(); chk("lw_c3", {stall_o, data_req}, 2'b10);
        adv();
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        mid(); chk("lw_c4", {stall_o, data_req}, 2'b10);
        adv();
        data_data_ok = 1'b0; data_rdata = '0;
        mid(); chk("lw_done", {stall_o, data_req, rdata_valid}, 3'b001);
        adv();
        mem_valid = 1'b0;
        mid(); chk("lw_after", {stall_o, data_req, rdata_valid}, 3'b000);
        chk("lw_hold", rdata_o, 32'hDEAD_BEEF);
        adv();

        xact("sb", EXE_SB_OP, 32'h2000_0003, 32'h1234_56A5, '0, 1'b1, SIZE_BYTE, 32'hA5A5_A5A5);
        xact("sh", EXE_SH_OP, 32'h2000_0002, 32'h0000_BEEF, '0, 1'b1, SIZE_HALF, 32'hBEEF_BEEF);
        xact("sw", EXE_SW_OP, 32'h2000_0008, 32'hCAFE_F00D, '0, 1'b1, SIZE_WORD, 32'hCAFE_F00D);
        xact("lbu", EXE_LBU_OP, 32'h3000_0003, 32'h5555_5555, 32'h0102_0304, 1'b0, SIZE_BYTE, 32'd0);
        xact("lhu", EXE_LHU_OP, 32'h3000_0002, '0, 32'h8765_4321, 1'b0, SIZE_HALF, 32'd0);

        // Misaligned ops fault in the same cycle and never reach the bus.
        mem_valid = 1'b1; mem_op = EXE_LH_OP; mem_addr = 32'h4000_0001;
        mid(); chk("lh_mis", {adel, ades, stall_o, data_req}, 4'b1000);
        adv();
        mid(); chk("lh_mis_noreq", data_req, 1'b0);
        mem_op = EXE_SW_OP; mem_addr = 32'h4000_0002;
        adv();
        mid(); chk("sw_mis", {adel, ades, stall_o, data_req}, 4'b0100);
        adv();
        mid(); chk("sw_mis_noreq", data_req, 1'b0);
        mem_op = EXE_LW_OP; mem_addr = 32'h4000_0001; flush = 1'b1;
        mid(); chk("lw_mis_flushed", {adel, ades, stall_o}, 3'b000);
        flush = 1'b0; mem_valid = 1'b0;
        adv();

        // Flush in REQ before addr_ok: abandon the request.
        mem_valid = 1'b1; mem_op = EXE_LW_OP; mem_addr = 32'h5000_0000;
        adv();
        flush = 1'b1; mem_valid = 1'b0;
        mid(); chk("fr_req", data_req, 1'b1);
        adv();
        flush = 1'b0;
        mid(); chk("fr_idle", {stall_o, data_req}, 2'b00);
        adv();
        mid(); chk("fr_hold", {rdata_valid, rdata_o}, {1'b0, last_rd});
        adv();

        // Flush in WAIT: drain the transfer, discard the data.
        mem_valid = 1'b1; mem_op = EXE_LW_OP; mem_addr = 32'h5000_0010;
        adv();
        data_addr_ok = 1'b1;
        adv();
        data_addr_ok = 1'b0; flush = 1'b1; mem_valid = 1'b0;
        mid(); chk("fw_wait_stall", stall_o, 1'b1);
        adv();
        flush = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h55AA_55AA;
        mid(); chk("fw_drain_stall", stall_o, 1'b1);
        adv();
        data_data_ok = 1'b0;
        mid(); chk("fw_done", {stall_o, rdata_valid, rdata_o}, {2'b00, last_rd});
        adv();

        // Reset during WAIT returns to IDLE and clears the read word.
        mem_valid = 1'b1; mem_op = EXE_LW_OP; mem_addr = 32'h6000_0000;
        adv();
        data_addr_ok = 1'b1;
        adv();
        data_addr_ok = 1'b0;
        mid(); chk("rw_wait", stall_o, 1'b1);
        resetn = 1'b0; mem_valid = 1'b0;
        adv();
        mid(); chk("rw_idle", {stall_o, data_req, rdata_valid}, 3'b000);
        chk("rw_rdata", rdata_o, 32'd0);
        last_rd = '0;
        resetn = 1'b1;
        adv();
        xact("lw_post", EXE_LW_OP, 32'h6000_0004, '0, 32'h0BAD_F00D, 1'b0, SIZE_WORD, 32'd0);

        chk("sb_empty", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
